// File: rtl/adam_block_seq.sv
// Sequencer turning ADAM 1 KiB block read/write commands into two 512-byte sector
// loads or flushes on the per-drive sector buffer, streaming the bytes with valid/ready.
module adam_block_seq #(
  parameter int drive_num = 0,
  parameter int TO_W      = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_rd,
  input  logic        cmd_wr,
  input  logic [31:0] blk_num,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  input  logic        rd_ready,
  input  logic        wr_valid,
  input  logic [7:0]  wr_data,
  output logic        wr_ready,
  input  logic [63:0] disk_size,
  input  logic        disk_present,
  output logic [31:0] disk_sector,
  output logic        disk_load,
  output logic        disk_flush,
  input  logic        disk_flushed,
  output logic [8:0]  disk_addr,
  output logic        disk_wr,
  output logic [7:0]  disk_din,
  input  logic [7:0]  disk_data
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_LOAD_W,
    S_RD_ADDR,
    S_RD_LAT,
    S_RD_OUT,
    S_WR_XFER,
    S_FLUSH,
    S_FLUSH_W,
    S_NEXT
  } state_t;

  // The wait aborts on the cycle the counter would reach 2**TO_W-1.
  localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};
  localparam logic [TO_W-1:0] TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};

  state_t          r_state;
  logic            r_isWr;
  logic            r_secIdx;
  logic [30:0]     r_blk;
  logic [8:0]      r_byteIdx;
  logic [TO_W-1:0] r_toCnt;
  logic            r_busy;
  logic            r_done;
  logic            r_error;
  logic            r_rdValid;
  logic [7:0]      r_rdData;
  logic            r_wrReady;
  logic            r_load;
  logic            r_flush;
  logic [31:0]     r_sector;

  logic [63:0]     w_blkEnd;
  logic            w_reject;
  logic            w_wrAccept;
  logic            w_unused_drive;

  assign w_blkEnd       = {22'd0, blk_num, 10'd0} + 64'd1024;
  assign w_reject       = ~disk_present | blk_num[31] | (w_blkEnd > disk_size);
  assign w_wrAccept     = wr_valid & r_wrReady;
  assign w_unused_drive = (drive_num != 0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_isWr    <= 1'b0;
      r_secIdx  <= 1'b0;
      r_blk     <= '0;
      r_byteIdx <= '0;
      r_toCnt   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_rdValid <= 1'b0;
      r_rdData  <= '0;
      r_wrReady <= 1'b0;
      r_load    <= 1'b0;
      r_flush   <= 1'b0;
      r_sector  <= '0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_rd & cmd_wr) begin
            r_error <= 1'b1;
          end else if (cmd_rd | cmd_wr) begin
            if (w_reject) begin
              r_error <= 1'b1;
            end else begin
              r_blk     <= blk_num[30:0];
              r_secIdx  <= 1'b0;
              r_isWr    <= cmd_wr;
              r_sector  <= {blk_num[30:0], 1'b0};
              r_byteIdx <= '0;
              r_busy    <= 1'b1;
              // A write fully overwrites the buffer, so it skips the load.
              if (cmd_wr) begin
                r_wrReady <= 1'b1;
                r_state   <= S_WR_XFER;
              end else begin
                r_load  <= 1'b1;
                r_state <= S_LOAD;
              end
            end
          end
        end

        S_LOAD: begin
          r_load  <= 1'b0;
          r_toCnt <= '0;
          r_state <= S_LOAD_W;
        end

        S_LOAD_W, S_FLUSH_W: begin
          if (disk_flushed) begin
            r_byteIdx <= '0;
            r_state   <= (r_state == S_LOAD_W) ? S_RD_ADDR : S_NEXT;
          end else if (r_toCnt == TO_LAST) begin
            r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_toCnt <= r_toCnt + TO_ONE;
          end
        end

        S_RD_ADDR: r_state <= S_RD_LAT;

        S_RD_LAT: begin
          r_rdData  <= disk_data;
          r_rdValid <= 1'b1;
          r_state   <= S_RD_OUT;
        end

        S_RD_OUT: begin
          if (rd_ready) begin
            r_rdValid <= 1'b0;
            if (r_byteIdx == 9'd511) begin
              r_state <= S_NEXT;
            end else begin
              r_byteIdx <= r_byteIdx + 9'd1;
              r_state   <= S_RD_ADDR;
            end
          end
        end

        S_WR_XFER: begin
          if (w_wrAccept) begin
            if (r_byteIdx == 9'd511) begin
              r_wrReady <= 1'b0;
              r_flush   <= 1'b1;
              r_state   <= S_FLUSH;
            end else begin
              r_byteIdx <= r_byteIdx + 9'd1;
            end
          end
        end

        S_FLUSH: begin
          r_flush <= 1'b0;
          r_toCnt <= '0;
          r_state <= S_FLUSH_W;
        end

        // Sector boundary: a lost image aborts here rather than mid-sector.
        S_NEXT: begin
          r_byteIdx <= '0;
          if (!disk_present) begin
            r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (!r_secIdx) begin
            r_secIdx <= 1'b1;
            r_sector <= {r_blk, 1'b1};
            if (r_isWr) begin
              r_wrReady <= 1'b1;
              r_state   <= S_WR_XFER;
            end else begin
              r_load  <= 1'b1;
              r_state <= S_LOAD;
            end
          end else begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign error       = r_error;
  assign rd_valid    = r_rdValid;
  assign rd_data     = r_rdData;
  assign wr_ready    = r_wrReady;
  assign disk_sector = r_sector;
  assign disk_load   = r_load;
  assign disk_flush  = r_flush;
  assign disk_addr   = r_byteIdx;
  assign disk_wr     = w_wrAccept;
  assign disk_din    = r_wrReady ? wr_data : 8'd0;

endmodule
